// File: rtl/address_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : address_arbiter                                              |
// | Description : Registered request/acknowledge arbiter for the shared memory |
// |               address bus. Grants one channel at a time and holds one      |
// |               outstanding access until the memory signals mem_ready.       |
// |               Lowest index wins by default. Define ADDR_ARB_ROUND_ROBIN_EN |
// |               to get rotating-pointer round-robin arbitration instead.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module address_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_CH     = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [NUM_CH-1:0]            req_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] addr_in_i,
  input  logic [NUM_CH-1:0]            we_in_i,
  input  logic                         mem_ready_i,
  output logic [ADDR_WIDTH-1:0]        address_bus_o,
  output logic                         mem_valid_o,
  output logic                         mem_we_o,
  output logic [NUM_CH-1:0]            grant_o,
  output logic [NUM_CH-1:0]            ack_o,
  output logic                         busy_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic                    valid_q, valid_d;
  logic [NUM_CH-1:0]       grant_q, grant_d;
  logic [NUM_CH-1:0]       ack_q, ack_d;

  // A channel being acked this cycle is masked so it can drop req in response.
  logic [NUM_CH-1:0]       w_eligible;
  logic [NUM_CH-1:0]       w_win_oh;
  logic                    w_found;
  logic [ADDR_WIDTH-1:0]   w_addr_sel;
  logic                    w_we_sel;

  assign w_eligible = req_i & ~ack_q;

`ifdef ADDR_ARB_ROUND_ROBIN_EN
  localparam int PTR_W = $clog2(NUM_CH);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] w_ptr_next;

  // Round-robin pick: first eligible channel at or after the pointer, wrapping.
  always_comb begin
    w_win_oh   = '0;
    w_found    = 1'b0;
    w_ptr_next = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!w_found && w_eligible[k] && (k == ((int'(ptr_q) + i) % NUM_CH))) begin
          w_found    = 1'b1;
          w_win_oh[k] = 1'b1;
          w_ptr_next = PTR_W'((k + 1) % NUM_CH);
        end
      end
    end
  end

  // Pointer advances past the winner only when a grant is actually issued.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && w_found) begin
      ptr_d = w_ptr_next;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority pick: scanning downward lets the lowest eligible index win.
  always_comb begin
    w_win_oh = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_eligible[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
    w_found = |w_eligible;
  end
`endif

  // Steer the winning channel's address and write enable toward the registers.
  always_comb begin
    w_addr_sel = '0;
    w_we_sel   = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_win_oh[k]) begin
        w_addr_sel = addr_in_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        w_we_sel   = we_in_i[k];
      end
    end
  end

  // Next-state logic: capture a winner in IDLE, hold everything until mem_ready.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    valid_d = valid_q;
    grant_d = grant_q;
    ack_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          addr_d  = w_addr_sel;
          we_d    = w_we_sel;
          grant_d = w_win_oh;
          valid_d = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (mem_ready_i) begin
          ack_d   = grant_q;
          grant_d = '0;
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any outstanding access without ack.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      grant_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
    end
  end

  assign address_bus_o = addr_q;
  assign mem_valid_o   = valid_q;
  assign mem_we_o      = we_q;
  assign grant_o       = grant_q;
  assign ack_o         = ack_q;
  assign busy_o        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_address_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_address_arbiter                                           |
// | Description : Directed bench for address_arbiter with an ack scoreboard.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_address_arbiter;

  localparam int AW = 16;
  localparam int NC = 2;

  typedef struct packed {
    logic [NC-1:0] g;
    logic [AW-1:0] a;
    logic          we;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [NC-1:0]    req;
  logic [NC*AW-1:0] addr_in;
  logic [NC-1:0]    we_in;
  logic             mem_ready;
  logic [AW-1:0]    address_bus;
  logic             mem_valid;
  logic             mem_we;
  logic [NC-1:0]    grant;
  logic [NC-1:0]    ack;
  logic             busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  address_arbiter #(.ADDR_WIDTH(AW), .NUM_CH(NC)) u_dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (req),
    .addr_in_i    (addr_in),
    .we_in_i      (we_in),
    .mem_ready_i  (mem_ready),
    .address_bus_o(address_bus),
    .mem_valid_o  (mem_valid),
    .mem_we_o     (mem_we),
    .grant_o      (grant),
    .ack_o        (ack),
    .busy_o       (busy)
  );

`ifdef ADDR_ARB_ROUND_ROBIN_EN
  logic [3:0]  rr_req;
  logic [63:0] rr_addr;
  logic [3:0]  rr_we;
  logic        rr_ready;
  logic [15:0] rr_abus;
  logic        rr_valid;
  logic        rr_mwe;
  logic [3:0]  rr_grant;
  logic [3:0]  rr_ack;
  logic        rr_busy;
  int          rr_q[$];

  address_arbiter #(.ADDR_WIDTH(16), .NUM_CH(4)) u_rr (
    .clk_i        (clk),
    .reset_i      (reset),
    .req_i        (rr_req),
    .addr_in_i    (rr_addr),
    .we_in_i      (rr_we),
    .mem_ready_i  (rr_ready),
    .address_bus_o(rr_abus),
    .mem_valid_o  (rr_valid),
    .mem_we_o     (rr_mwe),
    .grant_o      (rr_grant),
    .ack_o        (rr_ack),
    .busy_o       (rr_busy)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock, sample 1 time unit later and retire any ack against the scoreboard.
  task automatic tick();
    exp_t e;
    logic [3:0] one4;
    int ch;
    @(posedge clk);
    #1;
    if (ack !== '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("ack", 32'(ack), 32'(e.g));
        chk("ack_addr", 32'(address_bus), 32'(e.a));
        chk("ack_we", 32'(mem_we), 32'(e.we));
        chk("ack_valid_low", 32'(mem_valid), 32'h0);
      end
    end
`ifdef ADDR_ARB_ROUND_ROBIN_EN
    one4 = 4'b0001;
    if (rr_ack !== 4'b0000) begin
      if (rr_q.size() == 0) begin
        chk("rr_unexpected_ack", 32'(rr_ack), 32'h0);
      end else begin
        ch = rr_q.pop_front();
        chk("rr_ack", 32'(rr_ack), 32'(one4 << ch));
        chk("rr_ack_addr", 32'(rr_abus), 32'(16'h0100 * (ch + 1)));
      end
    end
`else
    one4 = 4'b0000;
    ch   = int'(one4);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    req       = 2'b11;
    addr_in   = {16'h5555, 16'hAAAA};
    we_in     = 2'b00;
    mem_ready = 1'b0;
`ifdef ADDR_ARB_ROUND_ROBIN_EN
    rr_req   = 4'b0000;
    rr_addr  = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    rr_we    = 4'b0000;
    rr_ready = 1'b0;
`endif

    // Reset held two cycles with every request asserted.
    tick();
    chk("rst1_valid", 32'(mem_valid), 32'h0);
    chk("rst1_grant", 32'(grant), 32'h0);
    tick();
    chk("rst_addr", 32'(address_bus), 32'h0);
    chk("rst_valid", 32'(mem_valid), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Release: IDLE samples the requests, channel 0 wins one cycle later.
    reset = 1'b0;
    sb.push_back('{g: 2'b01, a: 16'hAAAA, we: 1'b0});
    tick();
    chk("post_rst_valid", 32'(mem_valid), 32'h1);
    chk("post_rst_grant", 32'(grant), 32'h1);
    chk("post_rst_addr", 32'(address_bus), 32'hAAAA);
    chk("post_rst_busy", 32'(busy), 32'h1);
    req       = 2'b00;
    mem_ready = 1'b1;
    tick();
    chk("ack_cycle_busy", 32'(busy), 32'h0);
    tick();
    chk("idle_ready_valid", 32'(mem_valid), 32'h0);
    chk("idle_ready_ack", 32'(ack), 32'h0);
    mem_ready = 1'b0;

    // Single fetch on channel 1 with three-plus wait cycles.
    req     = 2'b10;
    addr_in = {16'h1234, 16'h0000};
    we_in   = 2'b00;
    sb.push_back('{g: 2'b10, a: 16'h1234, we: 1'b0});
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("single_addr", 32'(address_bus), 32'h1234);
      chk("single_grant", 32'(grant), 32'h2);
      chk("single_valid", 32'(mem_valid), 32'h1);
      if (c == 3) mem_ready = 1'b1;
    end
    tick();
    req       = 2'b00;
    mem_ready = 1'b0;
    tick();
    chk("single_ack_once", 32'(ack), 32'h0);
    chk("single_idle_valid", 32'(mem_valid), 32'h0);
    chk("single_idle_grant", 32'(grant), 32'h0);

    // Fixed priority: both request, channel 0 store goes first.
    req       = 2'b11;
    addr_in   = {16'h0040, 16'h00A0};
    we_in     = 2'b01;
    mem_ready = 1'b1;
    sb.push_back('{g: 2'b01, a: 16'h00A0, we: 1'b1});
    sb.push_back('{g: 2'b10, a: 16'h0040, we: 1'b0});
    tick();
    chk("prio_grant0", 32'(grant), 32'h1);
    chk("prio_addr0", 32'(address_bus), 32'h00A0);
    chk("prio_we0", 32'(mem_we), 32'h1);
    tick();
    req = 2'b10;
    tick();
    chk("prio_grant1", 32'(grant), 32'h2);
    chk("prio_addr1", 32'(address_bus), 32'h0040);
    chk("prio_we1", 32'(mem_we), 32'h0);
    tick();
    // Channel 1 keeps requesting: masked in its ack cycle, re-granted one cycle later.
    sb.push_back('{g: 2'b10, a: 16'h0040, we: 1'b0});
    tick();
    chk("regrant_gap_valid", 32'(mem_valid), 32'h0);
    tick();
    chk("regrant_grant", 32'(grant), 32'h2);
    chk("regrant_valid", 32'(mem_valid), 32'h1);
    req = 2'b00;
    tick();
    mem_ready = 1'b0;
    tick();

    // Inputs change and request drops while BUSY: access still completes.
    req     = 2'b01;
    addr_in = {16'h0000, 16'h1111};
    we_in   = 2'b00;
    sb.push_back('{g: 2'b01, a: 16'h1111, we: 1'b0});
    tick();
    chk("stab_grant", 32'(grant), 32'h1);
    chk("stab_addr", 32'(address_bus), 32'h1111);
    addr_in[15:0] = 16'hFFFF;
    we_in         = 2'b01;
    req           = 2'b00;
    tick();
    chk("stab_addr_held", 32'(address_bus), 32'h1111);
    chk("stab_we_held", 32'(mem_we), 32'h0);
    chk("stab_grant_held", 32'(grant), 32'h1);
    chk("stab_valid_held", 32'(mem_valid), 32'h1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();

    // Reset in the middle of an access discards it silently.
    req     = 2'b10;
    addr_in = {16'h2222, 16'h0000};
    we_in   = 2'b00;
    tick();
    chk("mid_valid", 32'(mem_valid), 32'h1);
    chk("mid_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(mem_valid), 32'h0);
    chk("mid_rst_grant", 32'(grant), 32'h0);
    chk("mid_rst_ack", 32'(ack), 32'h0);
    chk("mid_rst_addr", 32'(address_bus), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    sb.push_back('{g: 2'b10, a: 16'h2222, we: 1'b0});
    tick();
    chk("rereq_valid", 32'(mem_valid), 32'h1);
    chk("rereq_grant", 32'(grant), 32'h2);
    chk("rereq_addr", 32'(address_bus), 32'h2222);
    mem_ready = 1'b1;
    req       = 2'b00;
    tick();
    mem_ready = 1'b0;
    tick();

`ifdef ADDR_ARB_ROUND_ROBIN_EN
    // Round-robin over four channels, all requesting, zero-wait memory.
    begin
      int         order[5];
      logic [3:0] one;
      order = '{0, 1, 2, 3, 0};
      one   = 4'b0001;
      for (int i = 0; i < 5; i++) rr_q.push_back(order[i]);
      rr_req   = 4'b1111;
      rr_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (i % 2 == 0) begin
          chk("rr_grant", 32'(rr_grant), 32'(one << order[i / 2]));
        end
      end
      rr_req = 4'b0000;
      tick();
      rr_ready = 1'b0;
      tick();
      chk("rr_q_empty", 32'(rr_q.size()), 32'h0);
    end
`endif

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/address_arbiter.md
# address_arbiter

Parametrised, registered memory-address arbiter that drives the shared memory address bus on behalf of several requesters (instruction fetch from the program counter, data access from the MAR, and further masters such as a stack or DMA port). It replaces a purely state-decoded PC/MAR select with a request/acknowledge arbiter and a one-outstanding-transaction memory handshake. It sits between the control/datapath requesters and the memory interface.

## Interface
- `ADDR_WIDTH`, 16: width of every address input and of `address_bus`.
- `NUM_CH`, 2: number of requesting channels. Legal range is 2–8. Channel 0 is the MAR/data port and the last channel is the PC/fetch port by convention.
- `clk` input 1: single clock. All state updates on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `req` input NUM_CH: per-channel request level.
- `addr_in` input NUM_CH*ADDR_WIDTH: channel k address occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `we_in` input NUM_CH: per-channel write enable (1 = store, 0 = fetch).
- `mem_ready` input 1: memory accepts/completes the presented access in this cycle.
- `address_bus` output ADDR_WIDTH: registered address presented to memory.
- `mem_valid` output 1: `address_bus` and `mem_we` are valid; an access is outstanding.
- `mem_we` output 1: registered write enable of the granted channel.
- `grant` output NUM_CH: one-hot, the channel owning the outstanding access; all zero when idle.
- `ack` output NUM_CH: one-cycle pulse to the channel whose access completed.
- `busy` output 1: high whenever the FSM is not IDLE.

## Operation
- There are two states: IDLE and BUSY. After reset: IDLE, `address_bus`=0, `mem_valid`=0, `mem_we`=0, `grant`=0, `ack`=0, `busy`=0, and the round-robin pointer is 0.
- **IDLE:**
  - Eligible requests are `req & ~ack`. A channel is never re-granted in the cycle its ack is high, so a requester may drop `req` in response to `ack`.
  - If any request is eligible, pick a winner k, register `address_bus`←addr_in[k], `mem_we`←we_in[k], `grant`←onehot(k), `mem_valid`←1, and go to BUSY.
  - If no request is eligible, stay in IDLE. `address_bus` holds its last value.
- **BUSY:**
  - The outputs stay frozen. `addr_in` and `we_in` changes are ignored.
  - On `mem_ready`=1: `ack`←`grant` for one cycle, `grant`←0, `mem_valid`←0, and go to IDLE.
  - Withdrawal of `req` by the owner while BUSY does not abort the access; the access completes and is acked normally.
- **Arbitration:** fixed priority, with the lowest index winning. Round-robin applies when configured (see Configuration).
- A `mem_ready` seen in IDLE is ignored.
- Only one access is outstanding at any time. There is no queueing; losing channels keep `req` asserted.
- `reset` asserted in any state overrides all other inputs. It forces the reset values on the next edge and discards any outstanding access; no ack is issued for it.

## Timing
- **Grant latency:** request eligible at edge N → `mem_valid`, `grant`, and `address_bus` valid from edge N+1.
- **Completion:** if `mem_ready` is high at edge M while in BUSY, `ack` is high during cycle M+1, and in that cycle `mem_valid`=0.
- Minimum access occupies 2 cycles (zero-wait memory, `mem_ready` tied high). Back-to-back accesses by different channels therefore issue every 2 cycles.
- The same channel holding `req` continuously is re-granted at the earliest one cycle after its ack (3-cycle period).
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- The macro is `ADDR_ARB_ROUND_ROBIN_EN`.
- **Defined:**
  - Round-robin arbitration. The search starts at pointer p and wraps modulo NUM_CH.
  - On each grant, p←(winner+1) mod NUM_CH, wrapping from NUM_CH-1 back to 0.
  - The pointer resets to 0.
- **Undefined:** fixed priority with the lowest index winning. The pointer logic is absent.

## Test plan
- **Reset:** drive `reset`=1 for 2 cycles with `req`=all ones → all outputs 0. In the cycle after release, IDLE is sampled and `mem_valid` rises one cycle later.
- **Single access, ADDR_WIDTH=16, NUM_CH=2:**
  - Stimulus: ch1 `req`=1, addr 0x1234, `we`=0, `mem_ready` low for 3 cycles then high.
  - Required: `address_bus`=0x1234 and `grant`=2'b10 held for 4 cycles, then `ack`=2'b10 for exactly one cycle with `mem_valid`=0.
- **Fixed priority:** ch0 (0x00A0, `we`=1) and ch1 (0x0040) request together, `mem_ready`=1 → ch0 is served first with `mem_we`=1, then ch1 is granted the cycle after ch0's ack.
- **Round-robin (macro defined), NUM_CH=4:** all four `req` are held, `mem_ready`=1 → grant order is 0,1,2,3,0. It wraps after channel 3, with one grant every 2 cycles.
- **Stability and withdrawal:** while BUSY, change addr_in[0] to 0xFFFF and drop `req[0]` → `address_bus` is unchanged, and `ack[0]` still pulses on `mem_ready`.
- **Reset mid-access:** assert `reset` while BUSY with `mem_ready`=0 → the next cycle shows IDLE outputs with no `ack`. An access re-requested after reset behaves per the grant latency.
